sequencer: RTL
==============

// Module: sequencer
// PURPOSE
//  Instruction sequencer for the SM83 core: owns the instruction register (IR) and the M-cycle step counter.
//  Drives opcode/step into the decoder, consumes its done/is_cond/next_cond, evaluates branch conditions
//  against the flags and gates every step on the memory handshake. Fetch overlaps execute: the decoder's
//  done step reads [PC] and the byte read in that step is latched as the next opcode.
// PARAMETERS
//  RESET_OPCODE  8'h00  IR value held during the post-reset fetch (NOP)
//  MAX_STEP      3'd7   a step reaching this value without done/is_cond => fault
// PORTS
//  clk        in   1  core clock; all state updates on rising edge
//  rst        in   1  reset, asynchronous and active-high
//  mem_rdata  in   8  read data for the current M-cycle
//  mem_ready  in   1  current M-cycle's bus access completes this cycle
//  flags      in   4  {Z,N,H,C} from the register file
//  done       in   1  decoder: last step of the opcode
//  is_cond    in   1  decoder: branch on cc this step
//  next_cond  in   3  decoder: step to take when cc is NOT satisfied
//  write_mem  in   1  decoder: this step writes memory
//  opcode     out  8  IR, to decoder
//  step       out  3  current step, to decoder
//  fetch_ovr  out  1  forces s_ab=PC, idu=INC, wr_pc=1 (post-reset fetch only)
//  mem_req    out  1  bus access request for current M-cycle
//  mem_we     out  1  request is a write
//  fault      out  1  sticky: step overflow detected
// BEHAVIOUR
//  States: S_FETCH, S_EXEC, S_FAULT. Reset (async): state=S_FETCH, opcode=RESET_OPCODE, step=0, fault=0.
//  Outputs at reset: mem_req=1, mem_we=0, fetch_ovr=1, fault=0.
//  S_FETCH: fetch_ovr=1, mem_req=1, mem_we=0; decoder outputs ignored. On mem_ready: opcode<=mem_rdata,
//   step<=0, ->S_EXEC. No mem_ready: hold.
//  S_EXEC: fetch_ovr=0, mem_req=1, mem_we=write_mem. Nothing advances unless mem_ready=1 (stall holds
//   opcode, step, and request outputs stable). On mem_ready, priority order:
//   1) done: opcode<=mem_rdata, step<=0 (a 1-step opcode retires every M-cycle).
//   2) is_cond: cc=opcode[4:3]; 00 NZ(!Z), 01 Z, 10 NC(!C), 11 C. Satisfied => step+1, else step<=next_cond.
//   3) step==MAX_STEP: fault<=1, ->S_FAULT.
//   4) else step<=step+1.
//  done and is_cond together: done wins (cc ignored).
//  flags are sampled in the mem_ready cycle, not when the step began.
//  S_FAULT: mem_req=0, mem_we=0, opcode/step frozen; exit only by rst.
//  rst mid-stall or mid-opcode: immediate return to reset state; the in-flight access is abandoned.
//  mem_we never asserts in S_FETCH or S_FAULT. step arithmetic is 3-bit; the MAX_STEP check prevents wrap.
// CONFIGURATION
//  SEQ_TRACE_EN defined: extra outputs trace_valid(1), trace_opcode(8), trace_mcycles(4).
//   trace_valid pulses one clk on each retire (done && mem_ready in S_EXEC), carrying the retired
//   opcode and its M-cycle count (1..8, saturating at 15; stall cycles not counted). The counter
//   resets on rst and on retire.
//  SEQ_TRACE_EN undefined: ports and counter absent; core behaviour identical.
// TESTING
//  rst then mem_ready=1, mem_rdata=8'h78 -> 1 cycle in S_FETCH with fetch_ovr=1; then opcode=8'h78, step=0.
//  LD_R_R 8'h41 w/ done=1 each step, rdata stream 41,42,43 -> opcode updates every cycle, step stays 0.
//  JR NZ (8'h20) at step 1 with is_cond=1, next_cond=3, Z=1 -> step=3; Z=0 -> step=2.
//  mem_ready held low 5 cycles mid-step 1 of 8'hFA -> step/opcode/mem_req/mem_we unchanged;
//   advance on the 6th cycle.
//  step reaches 7 with done=0 and is_cond=0, mem_ready=1 -> fault=1, mem_req=0; frozen until rst.
//  rst asserted during a stalled write (mem_we=1) -> next clk opcode=8'h00, step=0, mem_we=0,
//   fetch_ovr=1.

Source files
------------

// File: rtl/sequencer_if.sv
// Memory handshake bundle between the instruction sequencer and the bus.
// master = sequencer (issues requests), slave = memory side.
interface sequencer_if;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;

  modport master (
    input  mem_rdata,
    input  mem_ready,
    output mem_req,
    output mem_we
  );

  modport slave (
    output mem_rdata,
    output mem_ready,
    input  mem_req,
    input  mem_we
  );
endinterface

// File: rtl/sequencer.sv
// SM83 instruction sequencer: owns IR and M-cycle step counter, evaluates branch conditions.
// Optional retire trace ports are enabled by defining SEQ_TRACE_EN.
module sequencer #(
  parameter logic [7:0] RESET_OPCODE = 8'h00,
  parameter logic [2:0] MAX_STEP     = 3'd7
) (
  input  logic              clk,
  input  logic              rst,
  sequencer_if.master       mem,
  input  logic [3:0]        flags,
  input  logic              done,
  input  logic              is_cond,
  input  logic [2:0]        next_cond,
  input  logic              write_mem,
  output logic [7:0]        opcode,
  output logic [2:0]        step,
  output logic              fetch_ovr,
  output logic              fault
`ifdef SEQ_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [7:0]        trace_opcode,
  output logic [3:0]        trace_mcycles
`endif
);

  localparam int unsigned OPC_W  = 8;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned MCYC_W = 4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opcode_q, opcode_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                fault_q, fault_d;
  logic                mem_req_q;
  logic                fetch_ovr_q;
  logic                cc_ok_c;
  logic                retire_c;
  logic                flags_unused;

  // N and H never take part in a branch decision.
  assign flags_unused = ^flags[2:1];

  // cc field of the JR/JP/CALL/RET family: NZ, Z, NC, C.
  always_comb begin
    cc_ok_c = 1'b0;
    case (opcode_q[4:3])
      2'b00:   cc_ok_c = ~flags[3];
      2'b01:   cc_ok_c =  flags[3];
      2'b10:   cc_ok_c = ~flags[0];
      default: cc_ok_c =  flags[0];
    endcase
  end

  // Next-state logic; every step is gated on the bus handshake.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    step_d   = step_q;
    fault_d  = fault_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          opcode_d = mem.mem_rdata;
          step_d   = STEP_W'(0);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (mem.mem_ready) begin
          if (done) begin
            // Fetch overlaps the final step: the byte read now is the next opcode.
            opcode_d = mem.mem_rdata;
            step_d   = STEP_W'(0);
            retire_c = 1'b1;
          end else if (is_cond) begin
            step_d = cc_ok_c ? step_q + STEP_W'(1) : next_cond;
          end else if (step_q == MAX_STEP) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      opcode_q    <= RESET_OPCODE;
      step_q      <= STEP_W'(0);
      fault_q     <= 1'b0;
      mem_req_q   <= 1'b1;
      fetch_ovr_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      step_q      <= step_d;
      fault_q     <= fault_d;
      mem_req_q   <= (state_d != S_FAULT);
      fetch_ovr_q <= (state_d == S_FETCH);
    end
  end

  assign opcode     = opcode_q;
  assign step       = step_q;
  assign fault      = fault_q;
  assign fetch_ovr  = fetch_ovr_q;
  assign mem.mem_req = mem_req_q;
  // Write strobe follows the decoder's current step, so it cannot be registered.
  assign mem.mem_we  = (state_q == S_EXEC) && write_mem;

`ifdef SEQ_TRACE_EN
  logic [MCYC_W-1:0] mcyc_q;
  logic [MCYC_W-1:0] mcyc_inc_c;
  logic              trace_valid_q;
  logic [OPC_W-1:0]  trace_opcode_q;
  logic [MCYC_W-1:0] trace_mcycles_q;

  assign mcyc_inc_c = (mcyc_q == {MCYC_W{1'b1}}) ? mcyc_q : mcyc_q + MCYC_W'(1);

  // Counts completed M-cycles of the current opcode; stalls do not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcyc_q          <= MCYC_W'(0);
      trace_valid_q   <= 1'b0;
      trace_opcode_q  <= OPC_W'(0);
      trace_mcycles_q <= MCYC_W'(0);
    end else begin
      trace_valid_q <= retire_c;
      if (retire_c) begin
        mcyc_q          <= MCYC_W'(0);
        trace_opcode_q  <= opcode_q;
        trace_mcycles_q <= mcyc_inc_c;
      end else if (state_q == S_EXEC && mem.mem_ready) begin
        mcyc_q <= mcyc_inc_c;
      end
    end
  end

  assign trace_valid   = trace_valid_q;
  assign trace_opcode  = trace_opcode_q;
  assign trace_mcycles = trace_mcycles_q;
`else
  logic retire_unused;
  assign retire_unused = retire_c;
`endif

endmodule
